// File: rtl/mult4_seq_ctrl_pkg.sv
// Shared constants for the shift-add multiplier controller and the 4-bit ALU it drives.
package mult4_seq_ctrl_pkg;

  localparam int WIDTH = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage

// File: rtl/mult4_seq_ctrl.sv
// Sequential 4x4 -> 8-bit unsigned shift-add multiplier controller; borrows the external ALU as its adder.
module mult4_seq_ctrl
  import mult4_seq_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product,
  output logic [WIDTH-1:0]   AluA,
  output logic [WIDTH-1:0]   AluB,
  output logic               AluCarryIn,
  output logic               AluBinvert,
  output logic [1:0]         AluOperation,
  input  logic [WIDTH-1:0]   AluResult,
  input  logic               AluCarryOut
);

  stateT                state, stateNext;
  logic [WIDTH-1:0]     mcand, mcandNext;
  // acc = {carry, hi nibble, lo nibble}; lo starts as the multiplier and shifts out as product bits arrive
  logic [2*WIDTH:0]     acc, accNext;
  logic [1:0]           cnt, cntNext;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      mcand <= mcandNext;
      acc   <= accNext;
      cnt   <= cntNext;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    mcandNext = mcand;
    accNext   = acc;
    cntNext   = cnt;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          mcandNext = Multiplicand;
          accNext   = {1'b0, {WIDTH{1'b0}}, Multiplier};
          cntNext   = '0;
          stateNext = CALC;
        end else begin
          stateNext = IDLE;
        end
      end
      CALC: begin
        // ALU carry lands in acc[8] before the shift so a full 15*15 stays exact
        if (acc[0])
          accNext = {AluCarryOut, AluResult, acc[WIDTH-1:0]} >> 1;
        else
          accNext = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:0]} >> 1;
        cntNext = 2'(cnt + 2'd1);
        if (cnt == 2'd3)
          stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign Busy         = (state == CALC);
  assign Done         = (state == DONE);
  assign Product      = acc[2*WIDTH-1:0];

  assign AluA         = acc[2*WIDTH-1:WIDTH];
  assign AluB         = mcand;
  assign AluCarryIn   = 1'b0;
  assign AluBinvert   = 1'b0;
  assign AluOperation = OP_ADD;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Directed bench for mult4_seq_ctrl with a behavioural 4-bit ALU wired to the Alu* ports.
module tb_mult4_seq_ctrl;
  import mult4_seq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start;
  logic [3:0] Multiplicand, Multiplier;
  logic       Busy, Done;
  logic [7:0] Product;
  logic [3:0] AluA, AluB, AluResult;
  logic       AluCarryIn, AluBinvert, AluCarryOut;
  logic [1:0] AluOperation;

  int checks = 0;
  int errors = 0;

  mult4_seq_ctrl dut (
    .clk(clk), .reset(reset), .Start(Start),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Busy(Busy), .Done(Done), .Product(Product),
    .AluA(AluA), .AluB(AluB), .AluCarryIn(AluCarryIn), .AluBinvert(AluBinvert),
    .AluOperation(AluOperation), .AluResult(AluResult), .AluCarryOut(AluCarryOut)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for alu4bit
  logic [3:0] bEff;
  logic [4:0] sum;
  always_comb begin
    bEff = AluBinvert ? ~AluB : AluB;
    sum  = {1'b0, AluA} + {1'b0, bEff} + {4'b0, AluCarryIn};
    AluCarryOut = sum[4];
    case (AluOperation)
      OP_AND:  AluResult = AluA & bEff;
      OP_OR:   AluResult = AluA | bEff;
      OP_ADD:  AluResult = sum[3:0];
      default: AluResult = {3'b0, sum[3]};
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue a request and follow it through Busy x4 and the Done cycle; ends one cycle after Done.
  task automatic runMult(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] expProd, input string tag);
    Start = 1'b1; Multiplicand = a; Multiplier = b;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, " busy"}, 16'(Busy), 16'd1);
      check({tag, " noDone"}, 16'(Done), 16'd0);
      tick();
    end
    check({tag, " done"}, 16'(Done), 16'd1);
    check({tag, " idleBusy"}, 16'(Busy), 16'd0);
    check({tag, " product"}, 16'(Product), 16'(expProd));
    check({tag, " aluOp"}, 16'(AluOperation), 16'(OP_ADD));
    tick();
    check({tag, " donePulse"}, 16'(Done), 16'd0);
    check({tag, " hold"}, 16'(Product), 16'(expProd));
  endtask

  initial begin
    int doneCount;
    logic [7:0] seenProd;

    reset = 1'b1; Start = 1'b0; Multiplicand = '0; Multiplier = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst busy",    16'(Busy), 16'd0);
    check("rst done",    16'(Done), 16'd0);
    check("rst product", 16'(Product), 16'h00);
    check("rst aluA",    16'(AluA), 16'd0);
    check("rst aluB",    16'(AluB), 16'd0);
    check("rst cin",     16'(AluCarryIn), 16'd0);
    check("rst binv",    16'(AluBinvert), 16'd0);
    check("rst aluOp",   16'(AluOperation), 16'b10);

    runMult(4'd5,  4'd3,  8'h0F, "5x3");
    runMult(4'd15, 4'd15, 8'hE1, "15x15");

    // Back-to-back: Start held high in DONE
    Start = 1'b1; Multiplicand = 4'd9; Multiplier = 4'd12;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b first busy", 16'(Busy), 16'd1);
      tick();
    end
    check("b2b first done", 16'(Done), 16'd1);
    check("b2b first product", 16'(Product), 16'h6C);
    Start = 1'b1; Multiplicand = 4'd0; Multiplier = 4'd7;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b second busy", 16'(Busy), 16'd1);
      check("b2b second noDone", 16'(Done), 16'd0);
      tick();
    end
    check("b2b second done", 16'(Done), 16'd1);
    check("b2b second product", 16'(Product), 16'h00);
    tick();

    // Start while Busy is ignored
    Start = 1'b1; Multiplicand = 4'd6; Multiplier = 4'd7;
    tick();
    Start = 1'b0;
    doneCount = 0;
    seenProd  = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        Start = 1'b1; Multiplicand = 4'd2; Multiplier = 4'd2;
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        doneCount++;
        seenProd = Product;
      end
      tick();
    end
    Start = 1'b0;
    check("ignore doneCount", 16'(doneCount), 16'd1);
    check("ignore product", 16'(seenProd), 16'h2A);
    check("ignore idle", 16'(Busy), 16'd0);

    // Asynchronous reset in the 2nd CALC cycle aborts without Done
    Start = 1'b1; Multiplicand = 4'd13; Multiplier = 4'd11;
    tick();
    Start = 1'b0;
    tick();
    check("abort inCalc", 16'(Busy), 16'd1);
    #2 reset = 1'b1;
    #1;
    check("abort busy",    16'(Busy), 16'd0);
    check("abort done",    16'(Done), 16'd0);
    check("abort product", 16'(Product), 16'h00);
    check("abort aluA",    16'(AluA), 16'd0);
    check("abort aluB",    16'(AluB), 16'd0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done || Busy) doneCount++;
      tick();
    end
    check("abort noDone", 16'(doneCount), 16'd0);
    runMult(4'd13, 4'd11, 8'h8F, "13x11");

    // Exhaustive sweep against a*b
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        Start = 1'b1; Multiplicand = 4'(a); Multiplier = 4'(b);
        tick();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (AluOperation !== OP_ADD)
            check($sformatf("sweep aluOp %0dx%0d", a, b), 16'(AluOperation), 16'(OP_ADD));
          tick();
        end
        check($sformatf("sweep done %0dx%0d", a, b), 16'(Done), 16'd1);
        check($sformatf("sweep product %0dx%0d", a, b), 16'(Product), 16'(a * b));
      end
    end
    check("sweep aluOp end", 16'(AluOperation), 16'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
